// File: rtl/mem_access_unit_if.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit_if
// Brief    : Data-memory req/ack bus between the MEM-stage unit and memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 2
`endif
`ifndef MASK_B
`define MASK_B 2'b00
`endif
`ifndef MASK_H
`define MASK_H 2'b01
`endif
`ifndef MASK_W
`define MASK_W 2'b10
`endif

interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit
// Brief    : MEM-stage load/store engine driving a req/ack data bus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 2
`endif
`ifndef MASK_B
`define MASK_B 2'b00
`endif
`ifndef MASK_H
`define MASK_H 2'b01
`endif
`ifndef MASK_W
`define MASK_W 2'b10
`endif

module mem_access_unit #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 5
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic [`REG_DATA_WIDTH-1:0] alu_res_mem,
    input  wire logic [`REG_DATA_WIDTH-1:0] bypass_op2_mem,
    input  wire logic                       mem_read_mem,
    input  wire logic                       mem_write_mem,
    input  wire logic [`MASK_WIDTH-1:0]     mask_mem,
    input  wire logic                       unsigned_load_mem,
    input  wire logic                       mem_hold,
    mem_access_unit_if.master               dbus,
    output logic [`REG_DATA_WIDTH-1:0]      load_data_mem,
    output logic                            stall_req_mem,
    output logic                            misalign_err,
    output logic                            bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(TIMEOUT - 1);

    state_t r_state, w_next_state;

    logic                       r_req, r_we, r_unsigned, r_bus_err;
    logic [31:0]                r_addr, r_wdata;
    logic [3:0]                 r_be;
    logic [1:0]                 r_off;
    logic [`MASK_WIDTH-1:0]     r_mask;
    logic [CNT_WIDTH-1:0]       r_cnt;
    logic [`REG_DATA_WIDTH-1:0] r_load;

    logic                       w_access, w_misalign, w_issue, w_timeout;
    logic [1:0]                 w_off;
    logic [3:0]                 w_be;
    logic [31:0]                w_wdata, w_shift;
    logic [`REG_DATA_WIDTH-1:0] w_ext;

    assign w_access   = mem_read_mem | mem_write_mem;
    assign w_off      = alu_res_mem[1:0];
    assign w_misalign = ((mask_mem == `MASK_H) && w_off[0]) ||
                        ((mask_mem == `MASK_W) && (w_off != 2'b00));
    assign w_issue    = (r_state == S_IDLE) && w_access && !w_misalign;
    assign w_timeout  = (r_state == S_REQ) && !dbus.ack && (r_cnt == c_cnt_last);

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bypass_op2_mem[31:0];
        case (mask_mem)
            `MASK_B: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bypass_op2_mem[7:0]}};
            end
            `MASK_H: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{bypass_op2_mem[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shift = dbus.rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_shift;
        case (r_mask)
            `MASK_B: w_ext = {{24{w_shift[7]  & ~r_unsigned}}, w_shift[7:0]};
            `MASK_H: w_ext = {{16{w_shift[15] & ~r_unsigned}}, w_shift[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        stall_req_mem = 1'b0;
        misalign_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                misalign_err  = w_access && w_misalign;
                stall_req_mem = w_issue;
                if (w_issue) w_next_state = S_REQ;
            end
            S_REQ: begin
                stall_req_mem = 1'b1;
                if (dbus.ack || w_timeout) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (!mem_hold) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_off      <= '0;
            r_mask     <= '0;
            r_unsigned <= 1'b0;
            r_cnt      <= '0;
            r_load     <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_issue) begin
                r_req      <= 1'b1;
                r_we       <= mem_write_mem;
                r_addr     <= {alu_res_mem[31:2], 2'b00};
                r_be       <= w_be;
                r_wdata    <= w_wdata;
                r_off      <= w_off;
                r_mask     <= mask_mem;
                r_unsigned <= unsigned_load_mem;
                r_cnt      <= '0;
            end
            if (r_state == S_REQ) begin
                if (dbus.ack) begin
                    r_req  <= 1'b0;
                    r_load <= w_ext;
                end else if (w_timeout) begin
                    r_req  <= 1'b0;
                    r_load <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign dbus.req      = r_req;
    assign dbus.we       = r_we;
    assign dbus.addr     = r_addr;
    assign dbus.be       = r_be;
    assign dbus.wdata    = r_wdata;
    assign load_data_mem = r_load;
    assign bus_err       = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit bus transactions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res_mem, bypass_op2_mem;
    logic        mem_read_mem, mem_write_mem, unsigned_load_mem, mem_hold;
    logic [1:0]  mask_mem;
    logic [31:0] load_data_mem;
    logic        stall_req_mem, misalign_err, bus_err;

    mem_access_unit_if dbus ();

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_res_mem       (alu_res_mem),
        .bypass_op2_mem    (bypass_op2_mem),
        .mem_read_mem      (mem_read_mem),
        .mem_write_mem     (mem_write_mem),
        .mask_mem          (mask_mem),
        .unsigned_load_mem (unsigned_load_mem),
        .mem_hold          (mem_hold),
        .dbus              (dbus.master),
        .load_data_mem     (load_data_mem),
        .stall_req_mem     (stall_req_mem),
        .misalign_err      (misalign_err),
        .bus_err           (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
        logic        berr;
        int          req_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] m, input logic uns, input int ack_after,
                                   input logic [31:0] rdata);
        exp_t e;
        int   nb, off;
        logic [31:0] v;
        nb  = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
        off = int'(a[1:0]);
        e.addr  = {a[31:2], 2'b00};
        e.we    = wr;
        e.be    = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % nb) +: 8];
        v = '0;
        for (int j = 0; j < nb; j++) v[8*j +: 8] = rdata[8*(off+j) +: 8];
        if (!uns && nb < 4 && v[8*nb-1])
            for (int k = 8*nb; k < 32; k++) v[k] = 1'b1;
        e.berr       = (ack_after == 0);
        e.load       = e.berr ? 32'h0 : v;
        e.req_cycles = e.berr ? TIMEOUT : ack_after;
        return e;
    endfunction

    task automatic idle_inputs();
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
    endtask

    // ack_after==0 means never acknowledge; hold_cycles keeps the unit parked in DONE.
    task automatic run_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] m, input logic uns, input int ack_after,
                              input logic [31:0] rdata, input int hold_cycles);
        exp_t e;
        int   n;
        mem_read_mem      = ~wr;
        mem_write_mem     = wr;
        alu_res_mem       = a;
        bypass_op2_mem    = d;
        mask_mem          = m;
        unsigned_load_mem = uns;
        sb.push_back(model(wr, a, d, m, uns, ack_after, rdata));
        #1;
        check_val("issue_stall", 32'(stall_req_mem), 32'd1);
        tick();
        mem_read_mem  = ~wr;
        mem_write_mem = ~(~wr);
        alu_res_mem   = 32'hFFFF_FFFF;
        e = sb[0];
        check_val("bus_we",    32'(dbus.we), 32'(e.we));
        check_val("bus_addr",  dbus.addr,    e.addr);
        check_val("bus_be",    32'(dbus.be), 32'(e.be));
        check_val("bus_wdata", dbus.wdata,   e.wdata);
        n = 0;
        while (dbus.req && n < 40) begin
            n++;
            if (stall_req_mem !== 1'b1) check_val("req_stall", 32'(stall_req_mem), 32'd1);
            if (n == ack_after) begin
                dbus.ack   = 1'b1;
                dbus.rdata = rdata;
            end
            tick();
            dbus.ack   = 1'b0;
            dbus.rdata = 32'h5A5A_5A5A;
        end
        e = sb.pop_front();
        check_val("req_cycles", 32'(n), 32'(e.req_cycles));
        check_val("done_stall", 32'(stall_req_mem), 32'd0);
        check_val("bus_err",    32'(bus_err), 32'(e.berr));
        if (!wr) check_val("load_data", load_data_mem, e.load);
        mem_hold = (hold_cycles > 0);
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            check_val("hold_no_req", 32'(dbus.req), 32'd0);
        end
        if (hold_cycles > 0) check_val("hold_load", load_data_mem, e.load);
        idle_inputs();
        mem_hold = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        alu_res_mem = '0; bypass_op2_mem = '0; mask_mem = 2'b10;
        unsigned_load_mem = 1'b0; mem_hold = 1'b0;
        dbus.ack = 1'b0; dbus.rdata = '0;
        tick(); tick();
        check_val("rst_req",   32'(dbus.req), 32'd0);
        check_val("rst_be",    32'(dbus.be),  32'd0);
        check_val("rst_addr",  dbus.addr,     32'd0);
        check_val("rst_wdata", dbus.wdata,    32'd0);
        check_val("rst_load",  load_data_mem, 32'd0);
        check_val("rst_berr",  32'(bus_err),  32'd0);
        rst = 1'b0;
        tick();

        run_access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 3, 32'hDEAD_BEEF, 0);
        run_access(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 1, 32'h80FF_0000, 0);
        run_access(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 2, 32'h80FF_0000, 0);
        run_access(1'b1, 32'h202, 32'h1234_ABCD, 2'b01, 1'b0, 2, 32'h0, 0);
        run_access(1'b0, 32'h002, 32'h0, 2'b01, 1'b0, 1, 32'h9876_0000, 0);
        run_access(1'b0, 32'h006, 32'h0, 2'b01, 1'b1, 4, 32'h9876_0000, 0);
        run_access(1'b1, 32'h301, 32'h0000_00A5, 2'b00, 1'b0, 1, 32'h0, 0);
        run_access(1'b0, 32'h101, 32'h0, 2'b00, 1'b0, TIMEOUT, 32'h0000_7F00, 0);
        run_access(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 0, 32'h0, 0);
        check_val("post_to_berr", 32'(bus_err), 32'd0);
        run_access(1'b0, 32'h500, 32'h0, 2'b10, 1'b0, 2, 32'hCAFE_F00D, 3);

        // Misaligned word: no bus cycle, no stall.
        mem_read_mem = 1'b1; alu_res_mem = 32'h101; mask_mem = 2'b10;
        #1;
        check_val("mis_err",   32'(misalign_err),  32'd1);
        check_val("mis_stall", 32'(stall_req_mem), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dbus.req !== 1'b0) check_val("mis_req", 32'(dbus.req), 32'd0);
        end
        mask_mem = 2'b01; alu_res_mem = 32'h103;
        #1;
        check_val("mis_half", 32'(misalign_err), 32'd1);
        idle_inputs();
        tick();

        // Reset mid-REQ aborts the access.
        mem_read_mem = 1'b1; alu_res_mem = 32'h600; mask_mem = 2'b10;
        tick();
        idle_inputs();
        check_val("pre_rst_req", 32'(dbus.req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_val("abort_req",   32'(dbus.req),      32'd0);
        check_val("abort_stall", 32'(stall_req_mem), 32'd0);
        rst = 1'b0;
        run_access(1'b0, 32'h700, 32'h0, 2'b00, 1'b0, 1, 32'h0000_0042, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
